// File: rtl/l1_cache_ctrl_pkg.sv
// Shared geometry, FSM state type and address-field helpers for the
// direct-mapped L1 cache controller and its line storage.
package cache_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int LINES  = 64;
    localparam int WORDS  = 8;
    localparam int TAG_W  = 6;
    localparam int IDX_W  = 6;
    localparam int OFF_W  = 3;
    localparam int CNT_W  = OFF_W + 1;
    localparam int MISS_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        COMMIT
    } state_e;

    // Byte address overlay: {tag, index, word offset, byte select}.
    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [IDX_W-1:0] idx;
        logic [OFF_W-1:0] off;
        logic             byte_sel;
    } addr_t;

    function automatic logic [TAG_W-1:0] addr_tag(input addr_t a);
        return a.tag;
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input addr_t a);
        return a.idx;
    endfunction

    function automatic logic [OFF_W-1:0] addr_off(input addr_t a);
        return a.off;
    endfunction

    function automatic logic [ADDR_W-1:0] fill_addr(
        input logic [TAG_W-1:0] tag,
        input logic [IDX_W-1:0] idx,
        input logic [OFF_W-1:0] off
    );
        return {tag, idx, off, 1'b0};
    endfunction

endpackage

// File: rtl/l1_cache_ctrl_if.sv
// CPU-side access port and memory-side port of one L1 cache controller.
interface l1_cache_ctrl_if;

    logic                          req_en;
    logic                          req_wr;
    logic [cache_pkg::ADDR_W-1:0]  req_addr;
    logic [cache_pkg::DATA_W-1:0]  req_wdata;
    logic [cache_pkg::DATA_W-1:0]  rdata;
    logic                          stall;
    logic                          mem_en;
    logic                          mem_wr;
    logic [cache_pkg::ADDR_W-1:0]  mem_addr;
    logic [cache_pkg::DATA_W-1:0]  mem_wdata;
    logic [cache_pkg::DATA_W-1:0]  mem_rdata;
    logic                          mem_rvalid;
    logic [cache_pkg::MISS_W-1:0]  miss_cnt;

    // The environment: CPU pipeline plus main memory.
    modport master (
        output req_en, req_wr, req_addr, req_wdata, mem_rdata, mem_rvalid,
        input  rdata, stall, mem_en, mem_wr, mem_addr, mem_wdata, miss_cnt
    );

    // The cache controller.
    modport slave (
        input  req_en, req_wr, req_addr, req_wdata, mem_rdata, mem_rvalid,
        output rdata, stall, mem_en, mem_wr, mem_addr, mem_wdata, miss_cnt
    );

endinterface

// File: rtl/l1_cache_ctrl_line_array.sv
// Line storage: LINES x WORDS data words with asynchronous read, plus a
// tag/valid array whose valid bits clear on reset.
module cache_line_array
    import cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  rd_idx,
    input  logic [OFF_W-1:0]  rd_off,
    output logic [DATA_W-1:0] rd_data,
    output logic [TAG_W-1:0]  rd_tag,
    output logic              rd_valid,
    input  logic              we,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [OFF_W-1:0]  wr_off,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              tag_we,
    input  logic [IDX_W-1:0]  tag_idx,
    input  logic [TAG_W-1:0]  tag_wdata
);

    logic [DATA_W-1:0] data_mem [LINES][WORDS];
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [LINES-1:0]  valid_q, valid_d;

    // NOTE: data and tag storage carry no reset; the valid bits alone make stale contents unreachable.
    always_ff @(posedge clk) begin
        if (we) begin
            data_mem[wr_idx][wr_off] <= wr_data;
        end
        if (tag_we) begin
            tag_mem[tag_idx] <= tag_wdata;
        end
    end

    always_comb begin
        valid_d = valid_q;
        if (tag_we) begin
            valid_d[tag_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    assign rd_data  = data_mem[rd_idx][rd_off];
    assign rd_tag   = tag_mem[rd_idx];
    assign rd_valid = valid_q[rd_idx];

endmodule

// File: rtl/l1_cache_ctrl.sv
// Direct-mapped, write-through, write-allocate L1 cache controller: hits
// complete combinationally, misses stall through an 8-word pipelined line fill.
module l1_cache_ctrl
    import cache_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    l1_cache_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0]  LINE_WORDS = CNT_W'(WORDS);
    localparam logic [ADDR_W-1:0] WORD_MASK  = ~ADDR_W'(1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]    rcv_cnt_q, rcv_cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic [MISS_W-1:0]   miss_cnt_q, miss_cnt_d;

    logic [TAG_W-1:0]    req_tag;
    logic [IDX_W-1:0]    req_idx;
    logic [OFF_W-1:0]    req_off;
    logic [DATA_W-1:0]   rd_data;
    logic [TAG_W-1:0]    rd_tag;
    logic                rd_valid;
    logic                hit;

    logic                arr_we;
    logic [IDX_W-1:0]    arr_idx;
    logic [OFF_W-1:0]    arr_off;
    logic [DATA_W-1:0]   arr_wdata;
    logic                tag_we;

    logic                stall;
    logic [DATA_W-1:0]   rdata;
    logic                mem_en;
    logic                mem_wr;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;

    assign req_tag = addr_tag(bus.req_addr);
    assign req_idx = addr_idx(bus.req_addr);
    assign req_off = addr_off(bus.req_addr);

    cache_line_array u_array (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (req_idx),
        .rd_off    (req_off),
        .rd_data   (rd_data),
        .rd_tag    (rd_tag),
        .rd_valid  (rd_valid),
        .we        (arr_we),
        .wr_idx    (arr_idx),
        .wr_off    (arr_off),
        .wr_data   (arr_wdata),
        .tag_we    (tag_we),
        .tag_idx   (idx_q),
        .tag_wdata (tag_q)
    );

    assign hit = bus.req_en & rd_valid & (rd_tag == req_tag);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        rcv_cnt_d   = rcv_cnt_q;
        idx_d       = idx_q;
        tag_d       = tag_q;
        miss_cnt_d  = miss_cnt_q;
        stall       = 1'b0;
        rdata       = '0;
        mem_en      = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        arr_we      = 1'b0;
        arr_idx     = req_idx;
        arr_off     = req_off;
        arr_wdata   = bus.req_wdata;
        tag_we      = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req_en) begin
                    if (hit) begin
                        if (bus.req_wr) begin
                            arr_we    = 1'b1;
                            mem_en    = 1'b1;
                            mem_wr    = 1'b1;
                            mem_addr  = bus.req_addr & WORD_MASK;
                            mem_wdata = bus.req_wdata;
                        end else begin
                            rdata = rd_data;
                        end
                    end else begin
                        stall       = 1'b1;
                        miss_cnt_d  = (miss_cnt_q == '1) ? miss_cnt_q : miss_cnt_q + MISS_W'(1);
                        idx_d       = req_idx;
                        tag_d       = req_tag;
                        issue_cnt_d = '0;
                        rcv_cnt_d   = '0;
                        state_d     = FILL;
                    end
                end
            end

            // Issue and receive sides advance independently; returns arrive in order.
            FILL: begin
                stall = 1'b1;
                if (issue_cnt_q < LINE_WORDS) begin
                    mem_en      = 1'b1;
                    mem_addr    = fill_addr(tag_q, idx_q, issue_cnt_q[OFF_W-1:0]);
                    issue_cnt_d = issue_cnt_q + CNT_W'(1);
                end
                if (bus.mem_rvalid) begin
                    arr_we    = 1'b1;
                    arr_idx   = idx_q;
                    arr_off   = rcv_cnt_q[OFF_W-1:0];
                    arr_wdata = bus.mem_rdata;
                    rcv_cnt_d = rcv_cnt_q + CNT_W'(1);
                    if (rcv_cnt_d == LINE_WORDS) begin
                        state_d = COMMIT;
                    end
                end
            end

            COMMIT: begin
                stall       = 1'b1;
                tag_we      = 1'b1;
                issue_cnt_d = '0;
                rcv_cnt_d   = '0;
                state_d     = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state updates use non-blocking assignments so all flops sample together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            issue_cnt_q <= '0;
            rcv_cnt_q   <= '0;
            idx_q       <= '0;
            tag_q       <= '0;
            miss_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            rcv_cnt_q   <= rcv_cnt_d;
            idx_q       <= idx_d;
            tag_q       <= tag_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    assign bus.stall     = stall;
    assign bus.rdata     = rdata;
    assign bus.mem_en    = mem_en;
    assign bus.mem_wr    = mem_wr;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.miss_cnt  = miss_cnt_q;

endmodule
